// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch/decode stage.
// Holds opcode/funct3 values, ALU control encodings, FSM states and the NOP word.
package fetch_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_CMP = 1'b1;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        BRWAIT
    } state_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I-type or B-type immediate.
// Ports: instr (instruction word) in, imm (sign-extended immediate) out.
module imm_gen
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [11:0] imm_i;
    logic [12:0] imm_b;
    logic        unused_bits;

    assign imm_i       = instr[31:20];
    assign imm_b       = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign unused_bits = ^instr[19:12];

    always_comb begin
        if (instr[6:0] == OP_BRANCH) begin
            imm = {{(DATA_WIDTH-13){imm_b[12]}}, imm_b};
        end else begin
            imm = {{(DATA_WIDTH-12){imm_i[11]}}, imm_i};
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: fetches over imem req/ack, decodes ADDI/BNE, issues via valid/ready.
// Ports: imem_* fetch port, dec_* handshake, AD1..ImmOp/pc_out fields, br_valid/EQ resolve, illegal.
module fetch_decode
    import fetch_pkg::*;
#(
    parameter int                  ADDR_WIDTH          = 32,
    parameter int                  DATA_WIDTH          = 32,
    parameter int                  REG_FILE_ADDR_WIDTH = 5,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           imem_req,
    output logic [ADDR_WIDTH-1:0]          imem_addr,
    input  logic                           imem_ack,
    input  logic [DATA_WIDTH-1:0]          imem_rdata,
    output logic                           dec_valid,
    input  logic                           dec_ready,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
    output logic                           WE3,
    output logic                           ALUsrc,
    output logic                           ALUctrl,
    output logic [DATA_WIDTH-1:0]          ImmOp,
    output logic [ADDR_WIDTH-1:0]          pc_out,
    input  logic                           br_valid,
    input  logic                           EQ,
    output logic                           illegal
);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   imm_dec;
    logic                    capture;
    logic                    accept;
    logic                    resolve;
    logic                    is_addi;
    logic                    is_bne;
    logic                    legal;

    imm_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_gen (
        .instr(imem_rdata[31:0]),
        .imm  (imm_dec)
    );

    assign is_addi   = (imem_rdata[6:0] == OP_IMM) &&
                       (imem_rdata[14:12] == F3_ADDI);
    assign is_bne    = (imem_rdata[6:0] == OP_BRANCH) &&
                       (imem_rdata[14:12] == F3_BNE);
    assign legal     = is_addi || is_bne;
    assign imem_addr = pc;
    assign pc_out    = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dec_valid = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        resolve   = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    capture   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                dec_valid = 1'b1;
                if (dec_ready) begin
                    accept = 1'b1;
                    // Only a BNE drives ALUctrl to compare.
                    state_nxt = (ALUctrl == ALU_CMP) ? BRWAIT : FETCH;
                end
            end
            BRWAIT: begin
                if (br_valid) begin
                    resolve   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            AD1     <= '0;
            AD2     <= '0;
            AD3     <= '0;
            WE3     <= 1'b0;
            ALUsrc  <= 1'b0;
            ALUctrl <= ALU_ADD;
            ImmOp   <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            if (capture) begin
                AD1     <= legal ? imem_rdata[19:15] : '0;
                AD2     <= is_bne ? imem_rdata[24:20] : '0;
                AD3     <= is_addi ? imem_rdata[11:7] : '0;
                WE3     <= is_addi;
                ALUsrc  <= is_addi;
                ALUctrl <= is_bne ? ALU_CMP : ALU_ADD;
                ImmOp   <= legal ? imm_dec : '0;
                illegal <= !legal;
            end
            if (accept && ALUctrl != ALU_CMP) begin
                pc <= pc + ADDR_WIDTH'(4);
            end
            if (resolve) begin
                // BNE is taken when the operands differ.
                pc <= EQ ? pc + ADDR_WIDTH'(4) : pc + ImmOp[ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios then random instruction stream.
// Expected fields and PC flow come from a behavioural ISA-level model.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  AD1;
    logic [4:0]  AD2;
    logic [4:0]  AD3;
    logic        WE3;
    logic        ALUsrc;
    logic        ALUctrl;
    logic [31:0] ImmOp;
    logic [31:0] pc_out;
    logic        br_valid;
    logic        EQ;
    logic        illegal;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .AD1       (AD1),
        .AD2       (AD2),
        .AD3       (AD3),
        .WE3       (WE3),
        .ALUsrc    (ALUsrc),
        .ALUctrl   (ALUctrl),
        .ImmOp     (ImmOp),
        .pc_out    (pc_out),
        .br_valid  (br_valid),
        .EQ        (EQ),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ISA-level meaning of an instruction word.
    function automatic void model(input logic [31:0] i,
                                  output logic [4:0] a1, output logic [4:0] a2,
                                  output logic [4:0] a3, output logic we,
                                  output logic src, output logic ctl,
                                  output logic bad, output logic br,
                                  output logic [31:0] imm);
        logic [12:0] boff;
        a1 = 0; a2 = 0; a3 = 0; we = 0; src = 0; ctl = 0;
        bad = 1; br = 0; imm = 0;
        boff = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (i[6:0] == 7'h13 && i[14:12] == 3'd0) begin
            a1 = i[19:15]; a3 = i[11:7]; we = 1; src = 1; bad = 0;
            imm = 32'($signed(i[31:20]));
        end else if (i[6:0] == 7'h63 && i[14:12] == 3'd1) begin
            a1 = i[19:15]; a2 = i[24:20]; ctl = 1; bad = 0; br = 1;
            imm = 32'($signed(boff));
        end
    endfunction

    task automatic check_reset();
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_dec_valid", 32'(dec_valid), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_WE3", 32'(WE3), 0);
        chk("rst_ALUsrc", 32'(ALUsrc), 0);
        chk("rst_ALUctrl", 32'(ALUctrl), 0);
        chk("rst_AD1", 32'(AD1), 0);
        chk("rst_AD2", 32'(AD2), 0);
        chk("rst_AD3", 32'(AD3), 0);
        chk("rst_ImmOp", ImmOp, 0);
        chk("rst_pc_out", pc_out, 0);
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (imem_req !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_reached", 32'(imem_req), 1);
    endtask

    task automatic do_instr(input logic [31:0] instr, input int ackd,
                            input int stall, input logic eq, input int brd,
                            input logic stray, input logic abort_br);
        logic [4:0]  a1, a2, a3;
        logic        we, src, ctl, bad, br;
        logic [31:0] imm;
        model(instr, a1, a2, a3, we, src, ctl, bad, br, imm);
        wait_fetch();
        for (int d = 0; d <= ackd; d++) begin
            chk("fetch_req", 32'(imem_req), 1);
            chk("fetch_addr", imem_addr, exp_pc);
            chk("fetch_dec_valid", 32'(dec_valid), 0);
            imem_ack   = (d == ackd);
            imem_rdata = (d == ackd) ? instr : $urandom;
            br_valid   = stray && (d != ackd);
            EQ         = 1'($urandom);
            @(negedge clk);
        end
        imem_ack = 0;
        br_valid = 0;
        for (int s = 0; s <= stall; s++) begin
            chk("issue_valid", 32'(dec_valid), 1);
            chk("issue_req", 32'(imem_req), 0);
            chk("AD1", 32'(AD1), 32'(a1));
            chk("AD2", 32'(AD2), 32'(a2));
            chk("AD3", 32'(AD3), 32'(a3));
            chk("WE3", 32'(WE3), 32'(we));
            chk("ALUsrc", 32'(ALUsrc), 32'(src));
            chk("ALUctrl", 32'(ALUctrl), 32'(ctl));
            chk("ImmOp", ImmOp, imm);
            chk("pc_out", pc_out, exp_pc);
            chk("illegal", 32'(illegal), (s == 0) ? 32'(bad) : 0);
            dec_ready = (s == stall);
            @(negedge clk);
        end
        dec_ready = 0;
        if (br && abort_br) begin
            chk("brwait_valid", 32'(dec_valid), 0);
            rst_n = 0;
            @(negedge clk);
            check_reset();
            rst_n    = 1;
            br_valid = 1;
            EQ       = 0;
            @(negedge clk);
            br_valid = 0;
            exp_pc   = 0;
        end else if (br) begin
            for (int b = 0; b <= brd; b++) begin
                chk("brwait_valid", 32'(dec_valid), 0);
                chk("brwait_req", 32'(imem_req), 0);
                br_valid = (b == brd);
                EQ       = eq;
                @(negedge clk);
            end
            br_valid = 0;
            exp_pc   = eq ? exp_pc + 32'd4 : exp_pc + imm;
        end else begin
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 2);
        if (k == 0) begin
            w[14:0] = {w[14:12] & 3'b000, w[11:7], 7'h13};
            w[14:12] = 3'd0;
        end else if (k == 1) begin
            w[6:0]   = 7'h63;
            w[14:12] = 3'd1;
        end else begin
            w[6:0] = ($urandom_range(0, 1) == 1) ? 7'h13 : 7'h63;
            if ($urandom_range(0, 2) == 0) w[6:0] = 7'h33;
            if (w[6:0] == 7'h13 && w[14:12] == 3'd0) w[14:12] = 3'd2;
            if (w[6:0] == 7'h63 && w[14:12] == 3'd1) w[14:12] = 3'd0;
        end
        return w;
    endfunction

    initial begin
        rst_n      = 0;
        imem_ack   = 0;
        imem_rdata = 0;
        dec_ready  = 0;
        br_valid   = 0;
        EQ         = 0;
        exp_pc     = 0;
        repeat (2) @(negedge clk);
        check_reset();
        rst_n = 1;

        do_instr(32'h0050_0513, 0, 0, 0, 0, 0, 0);
        do_instr(32'hFFF1_0093, 0, 3, 0, 0, 0, 0);
        chk("pc_before_bne", exp_pc, 32'd8);
        do_instr(32'hFE05_1EE3, 0, 0, 0, 2, 0, 0);
        chk("bne_taken_pc", exp_pc, 32'd4);
        do_instr(32'h0010_0093, 1, 0, 0, 0, 0, 0);
        do_instr(32'hFE05_1EE3, 0, 1, 1, 0, 0, 0);
        chk("bne_fall_pc", exp_pc, 32'd12);
        do_instr(32'h0030_0193, 4, 0, 0, 0, 1, 0);
        do_instr(32'h0000_0033, 0, 1, 0, 0, 0, 0);
        do_instr(32'hFE05_1EE3, 0, 0, 0, 0, 0, 1);
        do_instr(32'hFE05_1EE3, 0, 0, 0, 1, 0, 0);
        chk("wrap_pc", exp_pc, 32'hFFFF_FFFC);
        do_instr(32'h0050_0513, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            do_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 2),
                     1'($urandom), $urandom_range(0, 3), 1'($urandom), 0);
        end
        wait_fetch();
        chk("final_addr", imem_addr, exp_pc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Instruction fetch/decode stage directly upstream of the execute datapath (register file + ALU operand mux + ALU).
- Holds the PC and fetches 32-bit instructions over a req/ack instruction-memory port.
- Decodes the RV32I subset ADDI/BNE into register addresses, control, immediate and PC, and presents them with a valid/ready handshake.
- Stalls on each BNE until execute returns EQ, then redirects the PC; no speculation.

Parameters:
ADDR_WIDTH, 32, PC / instruction-memory address width
DATA_WIDTH, 32, instruction and immediate width
REG_FILE_ADDR_WIDTH, 5, register address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  ADDR_WIDTH  fetch address (= PC), stable while imem_req
imem_ack  in  1  imem_rdata valid this cycle
imem_rdata  in  DATA_WIDTH  instruction word
dec_valid  out  1  decoded fields valid
dec_ready  in  1  execute accepts fields
AD1  out  REG_FILE_ADDR_WIDTH  rs1
AD2  out  REG_FILE_ADDR_WIDTH  rs2
AD3  out  REG_FILE_ADDR_WIDTH  rd
WE3  out  1  register write enable
ALUsrc  out  1  1 = ImmOp as ALU operand 2
ALUctrl  out  1  0 = add, 1 = compare/sub
ImmOp  out  DATA_WIDTH  sign-extended immediate
pc_out  out  ADDR_WIDTH  PC of the issued instruction
br_valid  in  1  branch resolution valid, one-cycle pulse
EQ  in  1  ALU equality flag, sampled with br_valid
illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE, PC=RESET_PC, instruction register=0x00000013 (NOP).
  - imem_req, dec_valid, illegal, WE3, ALUsrc, ALUctrl = 0; AD1/AD2/AD3/ImmOp = 0; pc_out = RESET_PC.
  - Reset mid-fetch, mid-issue or mid-BRWAIT abandons the operation; a late imem_ack or br_valid after reset is ignored.
- FSM states: IDLE, FETCH, ISSUE, BRWAIT.
  - IDLE -> FETCH unconditionally on the next cycle.
  - FETCH:
    - imem_req=1 (combinational from state), imem_addr=PC.
    - On imem_ack: capture imem_rdata, register decoded fields, go to ISSUE.
    - Ack in the first request cycle is legal, so fetch latency is at least 1 cycle.
  - ISSUE:
    - dec_valid=1. All decoded outputs stay registered and stable while dec_valid && !dec_ready.
    - On dec_ready with a BNE: go to BRWAIT, PC unchanged.
    - On dec_ready with anything else: PC += 4, go to FETCH.
  - BRWAIT:
    - dec_valid=0, imem_req=0.
    - On br_valid: PC = EQ ? PC+4 : PC+ImmOp (BNE taken when not equal), go to FETCH.
    - br_valid in any other state is ignored.
- Decode, registered on capture:
  - ADDI (opcode 0010011, funct3 000): AD1=rs1, AD3=rd, WE3=1, ALUsrc=1, ALUctrl=0, ImmOp=sext(instr[31:20]), AD2=0.
  - BNE (opcode 1100011, funct3 001): AD1=rs1, AD2=rs2, WE3=0, ALUsrc=0, ALUctrl=1, ImmOp=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}), AD3=0.
  - Other: issued as NOP (all control 0, addresses 0, ImmOp=0); illegal pulses 1 cycle on capture; treated as non-branch.
- Arithmetic:
  - PC arithmetic is modulo 2^ADDR_WIDTH; 0xFFFFFFFC+4 wraps to 0.
  - ImmOp is added as two's complement, truncated to ADDR_WIDTH.
- Throughput: minimum 2 cycles per non-branch instruction (FETCH+ISSUE), 3 + resolution latency per BNE.
- pc_out equals the PC of the instruction currently presented.

Decomposition:
- Package fetch_pkg holds:
  - opcode/funct3 constants (OP_IMM, OP_BRANCH, F3_ADDI, F3_BNE);
  - ALUctrl encodings (ALU_ADD=0, ALU_CMP=1);
  - state enum (IDLE/FETCH/ISSUE/BRWAIT);
  - NOP constant 0x00000013.
- One sub-module, imm_gen: combinational I-type/B-type sign extension selected by opcode.

Test Plan:
- Reset then imem_ack same cycle with rdata 0x00500513 (addi x10,x0,5), dec_ready=1:
  - imem_addr=0 in the first FETCH cycle;
  - next cycle dec_valid=1, AD1=0, AD3=10, WE3=1, ALUsrc=1, ImmOp=5, pc_out=0;
  - next fetch at 4.
- Hold dec_ready=0 for 3 cycles on addi: dec_valid and all fields stable; imem_req=0; PC stays 0 until accept.
- PC=8, rdata 0xFE051EE3 (bne x10,x0,-4):
  - decode gives AD1=10, AD2=0, ALUctrl=1, ALUsrc=0, ImmOp=0xFFFFFFFC;
  - br_valid with EQ=0 -> next imem_addr=4;
  - repeat with EQ=1 -> next imem_addr=12.
- imem_ack delayed 4 cycles: imem_req and imem_addr stable throughout; stray br_valid during FETCH is ignored.
- rdata 0x00000033 (add, unsupported): illegal pulses once, issued with WE3=0, PC advances by 4.
- rst_n low during BRWAIT then high: IDLE, then fetch from RESET_PC; a br_valid arriving after reset does not redirect the PC.
